instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs field bundles into 32-bit instruction words and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
module instruction_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_last_i,
    input  logic [6:0]    opcode_i,
    input  logic [2:0]    funct3_i,
    input  logic [6:0]    funct7_i,
    input  logic [4:0]    s1_i,
    input  logic [4:0]    s2_i,
    input  logic [4:0]    de_i,
    input  logic [4:0]    i5_i,
    input  logic [6:0]    i7_i,
    input  logic [11:0]   i12_i,
    input  logic [19:0]   address_i,
    output logic          mem_we_o,
    input  logic          mem_ready_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          err_illegal_o,
    output logic          done_o,
    output logic [AW:0]   word_count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CntFull = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CntOne  = (PW + 1)'(1);
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [AW-1:0] AddrOne = AW'(1);
    localparam logic [AW:0]   WcOne   = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q;
    logic [PW:0]   count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW:0]   word_count_q;
    logic          err_q;
    logic          done_q;
    logic [31:0]   fifo_q [FIFO_DEPTH];

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (opcode_i)
            7'b0110011: enc_word = {funct7_i, s2_i, s1_i, funct3_i, de_i, opcode_i};
            7'b0010011: begin
                // Shift-immediate forms split the immediate into i7/i5.
                if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
                    enc_word = {i7_i, i5_i, s1_i, funct3_i, de_i, opcode_i};
                end else begin
                    enc_word = {i12_i, s1_i, funct3_i, de_i, opcode_i};
                end
            end
            7'b1100111, 7'b0000011, 7'b1111110:
                enc_word = {i12_i, s1_i, funct3_i, de_i, opcode_i};
            7'b1100011, 7'b0100011, 7'b1111111:
                enc_word = {i7_i, s2_i, s1_i, funct3_i, i5_i, opcode_i};
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1000000, 7'b0100000:
                enc_word = {address_i, de_i, opcode_i};
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready_o    = (state_q == StRun) && (count_q != CntFull);
    assign accept        = in_valid_i && in_ready_o;
    assign push          = accept && enc_legal;
    assign mem_we_o      = (count_q != '0);
    assign pop           = mem_we_o && mem_ready_i;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = fifo_q[rd_ptr_q];
    assign err_illegal_o = err_q;
    assign done_o        = done_q;
    assign word_count_o  = word_count_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            mem_addr_q   <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            err_q  <= accept && !enc_legal;
            done_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PtrOne;
                mem_addr_q   <= mem_addr_q + AddrOne;
                word_count_q <= word_count_q + WcOne;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StRun;
                        mem_addr_q   <= base_addr_i;
                        word_count_q <= '0;
                    end
                end
                StRun: begin
                    if (accept && in_last_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (count_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
